// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per
// clock, through a DIGIT-bit ripple slice with a registered carry between digits.
// Optional signed-overflow output enabled by defining DIGIT_SERIAL_ADDER_OVF_EN.
//
// state | meaning
// IDLE  | ready for operands (in_ready=1)
// RUN   | one digit added per cycle, STEPS cycles
// DONE  | result valid, held until out_ready
module digit_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    if (DIGIT < 1 || DIGIT > WIDTH) begin : g_cfg_err_range
        $error("digit_serial_adder: DIGIT must be in 1..WIDTH");
    end else if ((WIDTH % DIGIT) != 0) begin : g_cfg_err_div
        $error("digit_serial_adder: DIGIT must divide WIDTH exactly");
    end

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum_out;
    logic             r_cout_out;
    logic [DIGIT:0]   w_rc;
    logic [DIGIT-1:0] w_dbits;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_accept;
    logic             w_last;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum_out;
    assign cout      = r_cout_out;
    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_last    = (r_state == RUN) && (r_cnt == CW'(STEPS - 1));

    // Ripple full-adder slice over the low DIGIT bits of the operand shifters
    always_comb begin
        w_rc[0] = r_carry;
        w_dbits = '0;
        for (int i = 0; i < DIGIT; i++) begin
            w_dbits[i]  = r_a[i] ^ r_b[i] ^ w_rc[i];
            w_rc[i + 1] = (r_a[i] & r_b[i]) | (w_rc[i] & (r_a[i] ^ r_b[i]));
        end
    end

    // Partial-sum shift register; new digits enter at the top
    if (STEPS == 1) begin : g_one_step
        assign w_sum_next = w_dbits;
    end else begin : g_multi_step
        logic [WIDTH-DIGIT-1:0] r_part;

        assign w_sum_next = {w_dbits, r_part};

        // Keep the upper bits of the shifted partial sum between digits
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_part <= '0;
            end else if (w_accept) begin
                r_part <= '0;
            end else if (r_state == RUN) begin
                r_part <= w_sum_next[WIDTH-1:DIGIT];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; result drain and new accept never share an edge
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand shifters, carry, step counter and held result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_sum_out  <= '0;
            r_cout_out <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_rc[DIGIT];
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum_out  <= w_sum_next;
                r_cout_out <= w_rc[DIGIT];
            end
        end
    end

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    assign ovf = r_ovf;

    // Operand sign bits captured at accept; overflow registered with the sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (w_last) begin
            r_ovf <= (r_a_msb == r_b_msb) && (w_sum_next[WIDTH-1] != r_a_msb);
        end
    end
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder: WIDTH=8/DIGIT=2 main instance plus a
// WIDTH=8/DIGIT=8 instance. Overflow checks apply when DIGIT_SERIAL_ADDER_OVF_EN is defined.
module tb_digit_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] sum;
    logic       cout;

    logic       in_valid8 = 1'b0;
    logic       in_ready8;
    logic [7:0] a8 = 8'h00;
    logic [7:0] b8 = 8'h00;
    logic       cin8 = 1'b0;
    logic       out_valid8;
    logic       out_ready8 = 1'b1;
    logic [7:0] sum8;
    logic       cout8;

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic       ovf;
    logic       ovf8;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one edge on the main instance; returns just after E0
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ic);
        a = ia;
        b = ib;
        cin = ic;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges after E0 until out_valid; gives up at max_cyc
    task automatic wait_valid(input int max_cyc, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < max_cyc) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, sum, cout} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_low: got rdy=%b vld=%b sum=%h cout=%b, want rdy=1 vld=0 sum=00 cout=0",
                     in_ready, out_valid, sum, cout);
        end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({in_ready, out_valid, sum, cout} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_after: got rdy=%b vld=%b sum=%h cout=%b, want rdy=1 vld=0 sum=00 cout=0",
                     in_ready, out_valid, sum, cout);
        end
    endtask

    task automatic test_basic_add();
        int cyc;
        issue(8'h5A, 8'h3C, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_run_flags: got rdy=%b vld=%b want 0 0", in_ready, out_valid);
        end
        wait_valid(20, cyc);
        n_checks++;
        if (cyc !== 4) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles want 4", cyc);
        end
        n_checks++;
        if (sum !== 8'h96 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_sum: got sum=%h cout=%b want sum=96 cout=0", sum, cout);
        end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ovf: got %b want 1", ovf);
        end
`endif
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_drain: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_carry_ripple();
        int cyc;
        issue(8'hFF, 8'h00, 1'b1);
        wait_valid(20, cyc);
        n_checks++;
        if (cyc !== 4 || sum !== 8'h00 || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL ripple_ff: got cyc=%0d sum=%h cout=%b want cyc=4 sum=00 cout=1", cyc, sum, cout);
        end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ripple_ff_ovf: got %b want 0", ovf);
        end
`endif
        tick();
        issue(8'h80, 8'h80, 1'b0);
        wait_valid(20, cyc);
        n_checks++;
        if (cyc !== 4 || sum !== 8'h00 || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL ripple_80: got cyc=%0d sum=%h cout=%b want cyc=4 sum=00 cout=1", cyc, sum, cout);
        end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ripple_80_ovf: got %b want 1", ovf);
        end
`endif
        tick();
    endtask

    task automatic test_backpressure();
        int cyc;
        out_ready = 1'b0;
        issue(8'h12, 8'h34, 1'b1);
        a = 8'hFF;
        b = 8'hFF;
        cin = 1'b1;
        in_valid = 1'b1;
        wait_valid(20, cyc);
        n_checks++;
        if (cyc !== 4 || sum !== 8'h47 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_result: got cyc=%0d sum=%h cout=%b want cyc=4 sum=47 cout=0", cyc, sum, cout);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({out_valid, in_ready, sum, cout} !== {1'b1, 1'b0, 8'h47, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got vld=%b rdy=%b sum=%h cout=%b want vld=1 rdy=0 sum=47 cout=0",
                         i, out_valid, in_ready, sum, cout);
            end
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int seen;
        issue(8'h7F, 8'h01, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midrst_no_result: got %0d valid cycles want 0", seen);
        end
        issue(8'h7F, 8'h01, 1'b0);
        wait_valid(20, cyc);
        n_checks++;
        if (cyc !== 4 || sum !== 8'h80 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_fresh: got cyc=%0d sum=%h cout=%b want cyc=4 sum=80 cout=0", cyc, sum, cout);
        end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ovf: got %b want 1", ovf);
        end
`endif
        tick();
    endtask

    task automatic test_degenerate();
        int cyc;
        a8 = 8'hC8;
        b8 = 8'h64;
        cin8 = 1'b1;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        cyc = 0;
        while (!out_valid8 && cyc < 20) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc !== 1 || sum8 !== 8'h2D || cout8 !== 1'b1) begin
            n_fail++;
            $display("FAIL degen: got cyc=%0d sum=%h cout=%b want cyc=1 sum=2d cout=1", cyc, sum8, cout8);
        end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ovf8 !== 1'b0) begin
            n_fail++;
            $display("FAIL degen_ovf: got %b want 0", ovf8);
        end
`endif
        tick();
        n_checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL degen_drain: got vld=%b rdy=%b want 0 1", out_valid8, in_ready8);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        test_reset();
        test_basic_add();
        test_carry_ripple();
        test_backpressure();
        test_reset_mid_run();
        test_degenerate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

- Parametrised, multi-cycle successor to the team's 1-bit combinational full adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, through a DIGIT-bit ripple full-adder slice with a registered carry between digits.
- Valid/ready handshakes on input and output; drops in as an arithmetic unit wherever area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits; ≥ 1.
- DIGIT, 2, bits added per cycle; must divide WIDTH exactly. STEPS = WIDTH/DIGIT.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a + b + cin, low WIDTH bits.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow; present only with DIGIT_SERIAL_ADDER_OVF_EN.

## Operation
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid, load a, b and cin into shift registers, clear step counter, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - Add the low DIGIT bits of A and B plus the carry register.
    - Shift the DIGIT result bits into the top of the sum shift register; shift A and B right by DIGIT.
    - Update the carry register; increment the counter.
    - On the cycle with counter = STEPS-1: load sum/cout output registers, go to DONE.
  - DONE: out_valid=1, in_ready=0. sum/cout/ovf held stable. On out_ready, go to IDLE.
- in_ready is decoded from state == IDLE. in_valid is ignored outside IDLE; operand inputs are sampled only at the accept edge.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the final carry register value.
- ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]), using the MSBs captured at accept. It is registered with sum.
- DIGIT == WIDTH: STEPS=1, and RUN lasts one cycle.
- WIDTH % DIGIT ≠ 0 is a configuration error. Stop elaboration with a generate-time error.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
  - Internal shift registers, carry and counter are cleared.
- Reset mid-operation discards the operation immediately; no result is produced.
- After rst_n deasserts, the first accept can occur on the first rising edge.
- Latency: operands accepted at edge E0; out_valid rises after edge E_STEPS (STEPS cycles later). With WIDTH=8, DIGIT=2: 4 cycles.
- The result is consumed at the first edge where out_valid && out_ready; out_valid falls after that edge and in_ready rises.
- No same-edge result drain plus new accept. Minimum issue interval is STEPS+2 cycles.
- Backpressure: out_ready low holds DONE indefinitely. Outputs stay constant, no accept.
- sum/cout/ovf change only on the RUN→DONE edge and on reset. Their values are meaningful only while out_valid=1.

## Configuration
- DIGIT_SERIAL_ADDER_OVF_EN defined:
  - ovf port exists and is computed as above.
  - Two extra flops hold the captured operand MSBs.
- Not defined: no ovf port, no related logic. Remaining behaviour and timing are identical.

## Test plan
- Reset: assert rst_n=0 mid-idle → in_ready=1, out_valid=0, sum=0x00, cout=0 (ovf=0) while low and after release.
- Basic add (WIDTH=8, DIGIT=2): a=0x5A, b=0x3C, cin=0 accepted at E0 → out_valid high after E4, sum=0x96, cout=0, ovf=1.
- Full carry ripple across all digits: a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1, ovf=0. Then a=0x80, b=0x80, cin=0 → sum=0x00, cout=1, ovf=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid, and pulse in_valid with new operands during RUN and DONE.
  - Required: result held unchanged, in_ready=0 throughout, new operands not accepted.
  - After out_ready=1: one-cycle drain, then in_ready=1.
- Reset mid-RUN: accept a=0x7F, b=0x01, drop rst_n after 2 cycles → immediate IDLE, out_valid never asserts. A fresh a=0x7F, b=0x01 then yields sum=0x80, cout=0, ovf=1.
- Degenerate config WIDTH=8, DIGIT=8: a=0xC8, b=0x64, cin=1 → out_valid one cycle after accept, sum=0x2D, cout=1.
